mac_feed_sequencer: RTL and testbench

//  Upstream operand sequencer for the MAC_10xINT8 dot-product engine.

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_feed_sequencer.sv | 155 +++++++++++++++
 tb/tb_mac_feed_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared constants and state encoding for the MAC_10xINT8 operand feed path.
package mac_pkg;

  localparam int unsigned DATAW = 8;
  localparam int unsigned LANES = 10;
  localparam int unsigned DIN_W = 96;
  localparam int unsigned WIN_W = 88;

  localparam logic [1:0] FEED_NONE = 2'b00;
  localparam logic [1:0] FEED_A    = 2'b01;
  localparam logic [1:0] FEED_B    = 2'b10;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/mac_feed_sequencer.sv
// Groups (data, weight) beats into cfg_k-beat accumulation groups, ping-pongs the MAC
// double-buffer load strobes and flags when the MAC result is stable.
module mac_feed_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned KW        = 8,
  parameter int unsigned DRAIN_CYC = 5
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [KW-1:0]    cfg_k,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DIN_W-1:0] s_data,
  input  logic [WIN_W-1:0] s_weight,
  output logic [DIN_W-1:0] data_in,
  output logic [WIN_W-1:0] cascade_weight_in,
  output logic             load_bb_a,
  output logic             load_bb_b,
  output logic             load_buf_sel,
  output logic [1:0]       feed_sel,
  output logic             zero_en,
  output logic             ena,
  output logic             res_valid
);

  localparam int unsigned DW = $clog2(DRAIN_CYC + 1);

  state_e             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [KW-1:0]      cnt_q, cnt_d;
  logic               ping_q, ping_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic               active_q, active_d;
  logic [DIN_W-1:0]   data_q, data_d;
  logic [WIN_W-1:0]   weight_q, weight_d;
  logic               load_a_q, load_a_d;
  logic               load_b_q, load_b_d;
  logic               buf_sel_q, buf_sel_d;
  logic [1:0]         feed_sel_q, feed_sel_d;
  logic               zero_en_q, zero_en_d;
  logic               res_valid_q, res_valid_d;
  logic               beat;

  // Ready depends only on registered state so upstream can't form a valid->ready loop.
  assign s_ready = (state_q == StRun) && (cnt_q != k_q);
  assign beat    = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    ping_d      = ping_q;
    drain_d     = drain_q;
    active_d    = active_q;
    data_d      = data_q;
    weight_d    = weight_q;
    buf_sel_d   = buf_sel_q;
    load_a_d    = 1'b0;
    load_b_d    = 1'b0;
    feed_sel_d  = FEED_NONE;
    zero_en_d   = 1'b0;
    res_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          k_d      = (cfg_k == '0) ? KW'(1) : cfg_k;
          cnt_d    = '0;
          ping_d   = 1'b0;
          active_d = 1'b1;
          state_d  = StRun;
        end
      end
      StRun: begin
        if (beat) begin
          data_d     = s_data;
          weight_d   = s_weight;
          load_a_d   = ~ping_q;
          load_b_d   = ping_q;
          buf_sel_d  = ping_q;
          feed_sel_d = ping_q ? FEED_B : FEED_A;
          zero_en_d  = (cnt_q == '0);
          ping_d     = ~ping_q;
          cnt_d      = cnt_q + KW'(1);
          if (cnt_q + KW'(1) == k_q) begin
            drain_d = '0;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // drain_q reaches DRAIN_CYC on the done cycle; the following edge returns to idle.
        if (drain_q == DW'(DRAIN_CYC)) begin
          active_d = 1'b0;
          state_d  = StIdle;
        end else begin
          drain_d     = drain_q + DW'(1);
          res_valid_d = (drain_q == DW'(DRAIN_CYC - 1));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= StIdle;
      k_q         <= '0;
      cnt_q       <= '0;
      ping_q      <= 1'b0;
      drain_q     <= '0;
      active_q    <= 1'b0;
      data_q      <= '0;
      weight_q    <= '0;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      buf_sel_q   <= 1'b0;
      feed_sel_q  <= FEED_NONE;
      zero_en_q   <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      ping_q      <= ping_d;
      drain_q     <= drain_d;
      active_q    <= active_d;
      data_q      <= data_d;
      weight_q    <= weight_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      buf_sel_q   <= buf_sel_d;
      feed_sel_q  <= feed_sel_d;
      zero_en_q   <= zero_en_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign busy              = active_q;
  assign ena               = active_q;
  assign done              = res_valid_q;
  assign res_valid         = res_valid_q;
  assign data_in           = data_q;
  assign cascade_weight_in = weight_q;
  assign load_bb_a         = load_a_q;
  assign load_bb_b         = load_b_q;
  assign load_buf_sel      = buf_sel_q;
  assign feed_sel          = feed_sel_q;
  assign zero_en           = zero_en_q;

endmodule

// File: tb/tb_mac_feed_sequencer.sv
// Bench for mac_feed_sequencer: cycle-timestamp reference model, directed cases, random traffic.
module tb_mac_feed_sequencer;
  import mac_pkg::*;

  localparam int VW = 11 + DIN_W + WIN_W;

  logic             clk = 1'b0;
  logic             clr = 1'b1;
  logic [7:0]       cfg_k = '0;
  logic             start = 1'b0;
  logic             busy, done;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic [DIN_W-1:0] s_data = '0;
  logic [WIN_W-1:0] s_weight = '0;
  logic [DIN_W-1:0] data_in;
  logic [WIN_W-1:0] cascade_weight_in;
  logic             load_bb_a, load_bb_b, load_buf_sel, zero_en, ena, res_valid;
  logic [1:0]       feed_sel;

  int tests = 0;
  int fails = 0;

  mac_feed_sequencer dut (
    .clk              (clk),
    .clr              (clr),
    .cfg_k            (cfg_k),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .s_weight         (s_weight),
    .data_in          (data_in),
    .cascade_weight_in(cascade_weight_in),
    .load_bb_a        (load_bb_a),
    .load_bb_b        (load_bb_b),
    .load_buf_sel     (load_buf_sel),
    .feed_sel         (feed_sel),
    .zero_en          (zero_en),
    .ena              (ena),
    .res_valid        (res_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {s_ready, busy, ena, done, res_valid, load_bb_a, load_bb_b, load_buf_sel,
            feed_sel, zero_en, data_in, cascade_weight_in};
  endfunction

  function automatic int dot(input logic [DIN_W-1:0] d, input logic [WIN_W-1:0] w);
    int acc = 0;
    for (int j = 0; j < int'(LANES); j++) begin
      acc += int'($signed(d[j*8+:8])) * int'($signed(w[j*8+:8]));
    end
    return acc;
  endfunction

  // Reference model: tracks the group by beat count and the cycle number of its last strobe.
  int               m_cyc = 0;
  bit               m_valid = 0;
  bit               m_active = 0;
  int               m_k = 0;
  int               m_beats = 0;
  int               m_last = -1;
  logic [DIN_W-1:0] e_data = '0;
  logic [WIN_W-1:0] e_wt = '0;
  logic             e_a = 0, e_b = 0, e_sel = 0, e_zero = 0, e_res = 0;
  logic [1:0]       e_feed = 2'b00;

  function automatic bit m_ready();
    return m_active && (m_beats < m_k);
  endfunction

  always @(posedge clk) begin
    bit acc, st;
    m_cyc++;
    if (clr) begin
      m_valid = 1; m_active = 0; m_k = 0; m_beats = 0; m_last = -1;
      e_data = '0; e_wt = '0; e_a = 0; e_b = 0; e_sel = 0; e_zero = 0; e_res = 0;
      e_feed = 2'b00;
    end else begin
      acc = s_valid && m_ready();
      st  = !m_active && start;
      e_a = 0; e_b = 0; e_zero = 0; e_feed = 2'b00;
      if (acc) begin
        e_data = s_data;
        e_wt   = s_weight;
        e_a    = (m_beats % 2) == 0;
        e_b    = (m_beats % 2) == 1;
        e_sel  = e_b;
        e_feed = e_b ? 2'b10 : 2'b01;
        e_zero = (m_beats == 0);
        m_beats++;
        if (m_beats == m_k) m_last = m_cyc;
      end
      if (m_active && m_last >= 0 && m_cyc == m_last + 6) m_active = 0;
      if (st) begin
        m_active = 1;
        m_k      = (cfg_k == 0) ? 1 : int'(cfg_k);
        m_beats  = 0;
        m_last   = -1;
      end
      e_res = m_active && m_last >= 0 && m_cyc == m_last + 5;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle", dut_vec(), {m_ready(), m_active, m_active, e_res, e_res, e_a, e_b, e_sel,
                                 e_feed, e_zero, e_data, e_wt});
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic go(input logic [7:0] k);
    cfg_k = k; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      cyc();
      n++;
    end
    check("done_seen", VW'(res_valid), VW'(1));
  endtask

  task automatic rand_beat();
    s_data   = {$urandom, $urandom, $urandom};
    s_weight = {$urandom, $urandom, $urandom};
  endtask

  initial begin
    int n;
    int cnt;
    logic [DIN_W-1:0] d;
    logic [WIN_W-1:0] w;

    cyc(); cyc();
    clr = 1'b0;
    check("reset", dut_vec(), '0);

    // 1: single beat, lanes 1..10 against weights 10..1
    go(8'd1);
    check("t1_busy", VW'({busy, ena, s_ready}), VW'(3'b111));
    d = '0; w = '0;
    for (int j = 0; j < 10; j++) begin
      d[j*8+:8] = 8'(j + 1);
      w[j*8+:8] = 8'(10 - j);
    end
    s_data = d; s_weight = w; s_valid = 1'b1;
    cyc();
    s_valid = 1'b0;
    check("t1_strobe", VW'({load_bb_a, load_bb_b, load_buf_sel, feed_sel, zero_en}),
          VW'(6'b100011));
    check("t1_dot", VW'(dot(data_in, cascade_weight_in)), VW'(220));
    wait_done(n);
    check("t1_latency", VW'(n), VW'(5));
    cyc();

    // 2: K=4 with valid held high
    go(8'd4);
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_ready", VW'(s_ready), VW'(1));
      rand_beat();
      cyc();
      check("t2_feed", VW'({feed_sel, zero_en}), VW'({(i % 2 == 1) ? 2'b10 : 2'b01, i == 0}));
    end
    check("t2_ready_low", VW'(s_ready), VW'(0));
    s_valid = 1'b0;
    wait_done(n);
    cyc();

    // 3: K=3 with valid toggling 1,0,1,0,1
    go(8'd3);
    for (int j = 0; j < 10; j++) begin
      d[j*8+:8] = 8'(j - 5);
      w[j*8+:8] = 8'(j + 3);
    end
    s_data = d; s_weight = w;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      s_valid = (i % 2 == 0);
      cyc();
      if (i % 2 == 0) begin
        check("t3_feed", VW'(feed_sel), VW'((cnt % 2 == 1) ? 2'b10 : 2'b01));
        cnt++;
      end else begin
        check("t3_gap", VW'({load_bb_a, load_bb_b, feed_sel}), VW'(0));
      end
    end
    s_valid = 1'b0;
    wait_done(n);
    cyc();

    // 4: clr after two beats, then a fresh group must start on buffer A
    go(8'd4);
    s_valid = 1'b1;
    rand_beat(); cyc();
    rand_beat(); cyc();
    s_valid = 1'b0; clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("t4_clr", dut_vec(), '0);
    go(8'd1);
    s_valid = 1'b1; rand_beat();
    cyc();
    s_valid = 1'b0;
    check("t4_restart_a", VW'({load_bb_a, load_bb_b}), VW'(2'b10));
    wait_done(n);
    cyc();

    // 5: beat offered with start is not taken; start while busy is ignored
    cfg_k = 8'd2; start = 1'b1; s_valid = 1'b1; rand_beat();
    cyc();
    check("t5_no_beat_on_start", VW'({load_bb_a, load_bb_b}), VW'(0));
    cfg_k = 8'd7;
    cyc();
    start = 1'b0;
    check("t5_beat1", VW'(load_bb_a), VW'(1));
    rand_beat();
    cyc();
    check("t5_beat2_k_kept", VW'({load_bb_b, s_ready}), VW'(2'b10));
    s_valid = 1'b0;
    wait_done(n);
    cyc();

    // 6: cfg_k=0 acts as K=1
    go(8'd0);
    s_valid = 1'b1; rand_beat();
    cyc();
    s_valid = 1'b0;
    check("t6_one_beat", VW'({load_bb_a, s_ready}), VW'(2'b10));
    wait_done(n);
    check("t6_latency", VW'(n), VW'(5));
    cyc();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      clr     = ($urandom_range(0, 299) == 0);
      start   = ($urandom_range(0, 5) == 0);
      cfg_k   = 8'($urandom_range(0, 6));
      s_valid = ($urandom_range(0, 2) != 0);
      rand_beat();
      cyc();
    end
    clr = 1'b0; start = 1'b0; s_valid = 1'b0;
    repeat (10) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
